// File: rtl/cart_pkg.sv
// Shared cartridge definitions: fetch FSM states, mapper-mode encodings and bus widths.
package cart_pkg;

  localparam int unsigned PRG_PAGE_W = 14;
  localparam int unsigned CPU_A_W    = 15;
  localparam int unsigned CHR_A_W    = 14;
  localparam int unsigned BYTE_W     = 8;

  // FIXED_HIGH encodings: which half of the CPU window is hard-wired
  localparam int unsigned MODE_MAPPER180 = 0;
  localparam int unsigned MODE_UXROM     = 1;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FETCH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/prg_fetch_ctrl.sv
// PRG fetch sequencer: holds the console in reset until preload, then keeps a
// one-byte cache of the ROM byte at the current CPU address.
module prg_fetch_ctrl
  import cart_pkg::*;
#(
  parameter int unsigned ADDR_W = 21
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              i_init_done,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_mem_ready,
  input  logic [BYTE_W-1:0] i_mem_data,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic              o_mem_req,
  output logic [BYTE_W-1:0] o_data_q,
  output logic              o_rst_out
);

  fetch_state_e      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_mem_address, w_mem_address_nxt;
  logic [ADDR_W-1:0] r_last_addr, w_last_addr_nxt;
  logic [BYTE_W-1:0] r_data_q, w_data_q_nxt;
  logic              r_mem_req, w_mem_req_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_rst_out, w_rst_out_nxt;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state       <= ST_HOLD;
      r_mem_address <= '0;
      r_last_addr   <= '0;
      r_data_q      <= '0;
      r_mem_req     <= 1'b0;
      r_valid       <= 1'b0;
      r_rst_out     <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_mem_address <= w_mem_address_nxt;
      r_last_addr   <= w_last_addr_nxt;
      r_data_q      <= w_data_q_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_valid       <= w_valid_nxt;
      r_rst_out     <= w_rst_out_nxt;
    end
  end

  // A launched fetch always runs to completion; a stale result is refetched from IDLE
  always_comb begin
    w_state_nxt       = r_state;
    w_mem_address_nxt = r_mem_address;
    w_last_addr_nxt   = r_last_addr;
    w_data_q_nxt      = r_data_q;
    w_mem_req_nxt     = r_mem_req;
    w_valid_nxt       = r_valid;
    w_rst_out_nxt     = r_rst_out;
    case (r_state)
      ST_HOLD: begin
        w_mem_req_nxt = 1'b0;
        w_rst_out_nxt = 1'b1;
        if (i_init_done) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (!r_valid || (i_addr != r_last_addr)) begin
          w_mem_address_nxt = i_addr;
          w_mem_req_nxt     = 1'b1;
          w_state_nxt       = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (i_mem_ready) begin
          w_data_q_nxt    = i_mem_data;
          w_last_addr_nxt = r_mem_address;
          w_valid_nxt     = 1'b1;
          w_mem_req_nxt   = 1'b0;
          w_rst_out_nxt   = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_mem_req_nxt = 1'b0;
        w_state_nxt   = ST_HOLD;
      end
    endcase
  end

  assign o_mem_address = r_mem_address;
  assign o_mem_req     = r_mem_req;
  assign o_data_q      = r_data_q;
  assign o_rst_out     = r_rst_out;

endmodule

// File: rtl/cart_uxrom_gen.sv
// UxROM / mapper-180 cartridge: PRG bank register, bank decode, CHR-RAM and
// CIRAM control, with ROM bytes fetched from an external memory.
module cart_uxrom_gen
  import cart_pkg::*;
#(
  parameter int unsigned PRG_BANK_BITS = 3,
  parameter int unsigned FIXED_HIGH    = 1,
  parameter int unsigned BUS_CONFLICT  = 0,
  parameter int unsigned MIRROR_V      = 1,
  parameter int unsigned ADDR_W        = 21
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic               prg_nce_in,
  input  logic [CPU_A_W-1:0] prg_a_in,
  input  logic               prg_r_nw_in,
  input  logic [BYTE_W-1:0]  prg_d_in,
  output logic [BYTE_W-1:0]  prg_d_out,
  input  logic [CHR_A_W-1:0] chr_a_in,
  input  logic               chr_r_nw_in,
  output logic               ciram_nce_out,
  output logic               ciram_a10_out,
  output logic               chrram_we,
  output logic [ADDR_W-1:0]  mem_address,
  output logic               mem_req,
  input  logic               mem_ready,
  input  logic [BYTE_W-1:0]  mem_data,
  input  logic               init_done,
  output logic               rst_out
);

  if (ADDR_W < PRG_BANK_BITS + PRG_PAGE_W) begin : g_bad_addr_w
    $error("cart_uxrom_gen: ADDR_W must be at least PRG_BANK_BITS+14");
  end

  logic [PRG_BANK_BITS-1:0] r_bank;
  logic                     r_strobe_q;
  logic                     w_strobe;
  logic                     w_bank_we;
  logic [PRG_BANK_BITS-1:0] w_bank_wdata;
  logic [PRG_BANK_BITS-1:0] w_bank;
  logic [ADDR_W-1:0]        w_addr;
  logic [BYTE_W-1:0]        w_data_q;
  logic                     w_unused;

  // One register write per CPU write strobe, taken on its leading edge
  assign w_strobe  = ~prg_nce_in & ~prg_r_nw_in;
  assign w_bank_we = w_strobe & ~r_strobe_q;

  // With bus conflicts the ROM drives the bus too, so the ROM byte masks the data
  assign w_bank_wdata = (BUS_CONFLICT != 0)
                      ? (prg_d_in[PRG_BANK_BITS-1:0] & w_data_q[PRG_BANK_BITS-1:0])
                      : prg_d_in[PRG_BANK_BITS-1:0];

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_bank     <= '0;
      r_strobe_q <= 1'b0;
    end else begin
      r_strobe_q <= w_strobe;
      if (w_bank_we) r_bank <= w_bank_wdata;
    end
  end

  always_comb begin
    w_bank = r_bank;
    if (FIXED_HIGH == MODE_UXROM) begin
      if (prg_a_in[PRG_PAGE_W]) w_bank = {PRG_BANK_BITS{1'b1}};
    end else begin
      w_bank = prg_a_in[PRG_PAGE_W] ? r_bank : '0;
    end
  end

  assign w_addr = ADDR_W'({w_bank, prg_a_in[PRG_PAGE_W-1:0]});

  prg_fetch_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_fetch (
    .clk_sys       (clk_sys),
    .rst           (rst),
    .i_init_done   (init_done),
    .i_addr        (w_addr),
    .i_mem_ready   (mem_ready),
    .i_mem_data    (mem_data),
    .o_mem_address (mem_address),
    .o_mem_req     (mem_req),
    .o_data_q      (w_data_q),
    .o_rst_out     (rst_out)
  );

  assign prg_d_out = prg_nce_in ? '0 : w_data_q;

  assign ciram_nce_out = ~chr_a_in[13];
  assign ciram_a10_out = (MIRROR_V != 0) ? chr_a_in[10] : chr_a_in[11];
  assign chrram_we     = ~chr_a_in[13] & ~chr_r_nw_in;

  assign w_unused = &{1'b0, prg_d_in, chr_a_in};

endmodule

// File: tb/tb_cart_uxrom_gen.sv
// Bench for cart_uxrom_gen: three parameterisations share CPU/PPU stimulus, each
// served by its own latency-programmable memory model.
module tb_cart_uxrom_gen;

  localparam int unsigned AW = 21;

  logic          clk_sys = 1'b0;
  logic          rst = 1'b1;
  logic          prg_nce = 1'b1;
  logic          prg_rnw = 1'b1;
  logic [14:0]   prg_a = 15'h0123;
  logic [7:0]    prg_d = 8'h00;
  logic [13:0]   chr_a = 14'h0000;
  logic          chr_rnw = 1'b1;
  logic          init_done = 1'b0;

  logic [7:0]    d_out [3];
  logic          nce_o [3];
  logic          a10_o [3];
  logic          we_o  [3];
  logic [AW-1:0] maddr [3];
  logic          mreq  [3];
  logic          mrdy  [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0]    mdat  [3] = '{8'h00, 8'h00, 8'h00};
  logic          rsto  [3];

  int            lat = 2;
  logic          ovr_en  [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0]    ovr_val [3] = '{8'h00, 8'h00, 8'h00};
  int            req_cnt  [3] = '{0, 0, 0};
  int            done_cnt [3] = '{0, 0, 0};
  logic [AW-1:0] done_addr [3][256];

  int            n_cmp = 0;
  int            n_err = 0;
  int            m_bank [3] = '{0, 0, 0};
  logic [14:0]   m_a = 15'h0123;

  always #5 clk_sys = ~clk_sys;

  cart_uxrom_gen u_def (
    .clk_sys(clk_sys), .rst(rst), .prg_nce_in(prg_nce), .prg_a_in(prg_a),
    .prg_r_nw_in(prg_rnw), .prg_d_in(prg_d), .prg_d_out(d_out[0]),
    .chr_a_in(chr_a), .chr_r_nw_in(chr_rnw), .ciram_nce_out(nce_o[0]),
    .ciram_a10_out(a10_o[0]), .chrram_we(we_o[0]), .mem_address(maddr[0]),
    .mem_req(mreq[0]), .mem_ready(mrdy[0]), .mem_data(mdat[0]),
    .init_done(init_done), .rst_out(rsto[0]));

  cart_uxrom_gen #(.FIXED_HIGH(0), .MIRROR_V(0)) u_m180 (
    .clk_sys(clk_sys), .rst(rst), .prg_nce_in(prg_nce), .prg_a_in(prg_a),
    .prg_r_nw_in(prg_rnw), .prg_d_in(prg_d), .prg_d_out(d_out[1]),
    .chr_a_in(chr_a), .chr_r_nw_in(chr_rnw), .ciram_nce_out(nce_o[1]),
    .ciram_a10_out(a10_o[1]), .chrram_we(we_o[1]), .mem_address(maddr[1]),
    .mem_req(mreq[1]), .mem_ready(mrdy[1]), .mem_data(mdat[1]),
    .init_done(init_done), .rst_out(rsto[1]));

  cart_uxrom_gen #(.BUS_CONFLICT(1)) u_bc (
    .clk_sys(clk_sys), .rst(rst), .prg_nce_in(prg_nce), .prg_a_in(prg_a),
    .prg_r_nw_in(prg_rnw), .prg_d_in(prg_d), .prg_d_out(d_out[2]),
    .chr_a_in(chr_a), .chr_r_nw_in(chr_rnw), .ciram_nce_out(nce_o[2]),
    .ciram_a10_out(a10_o[2]), .chrram_we(we_o[2]), .mem_address(maddr[2]),
    .mem_req(mreq[2]), .mem_ready(mrdy[2]), .mem_data(mdat[2]),
    .init_done(init_done), .rst_out(rsto[2]));

  function automatic logic [7:0] rom(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h3C;
  endfunction

  // Byte address in the 16 KB-banked image seen by the CPU at a
  function automatic logic [AW-1:0] map_addr(input int g, input int bank, input logic [14:0] a);
    int sel;
    int fixed_high;
    fixed_high = (g == 1) ? 0 : 1;
    if (a[14]) sel = fixed_high ? 7 : bank;
    else       sel = fixed_high ? bank : 0;
    return AW'(sel * 16384 + int'(a[13:0]));
  endfunction

  // Memory model: accepts a request, answers after lat cycles with a one-cycle pulse
  for (genvar g = 0; g < 3; g++) begin : g_mem
    int            cnt = 0;
    bit            busy = 1'b0;
    logic [AW-1:0] cap = '0;
    always @(posedge clk_sys) begin
      #1;
      mrdy[g] = 1'b0;
      if (busy) begin
        cnt = cnt - 1;
        if (cnt <= 0) begin
          mrdy[g] = 1'b1;
          mdat[g] = ovr_en[g] ? ovr_val[g] : rom(cap);
          done_addr[g][done_cnt[g] % 256] = cap;
          done_cnt[g] = done_cnt[g] + 1;
          busy = 1'b0;
        end
      end else if (mreq[g]) begin
        busy = 1'b1;
        cnt = lat;
        cap = maddr[g];
        req_cnt[g] = req_cnt[g] + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic settle(input string nm);
    int quiet;
    quiet = 0;
    for (int i = 0; i < 80 && quiet < 3; i++) begin
      tick();
      if (!mreq[0] && !mreq[1] && !mreq[2]) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: fetch activity never settled", nm);
    end
  endtask

  task automatic wait_req(input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = mreq[0];
    end
    chk(nm, 32'(got), 32'd1);
  endtask

  task automatic set_read(input logic [14:0] a, input string nm);
    prg_a = a;
    prg_nce = 1'b0;
    prg_rnw = 1'b1;
    settle(nm);
  endtask

  // Bank write; the bus-conflict part sees the byte of its last completed fetch
  task automatic do_write(input logic [7:0] d, input logic [14:0] a);
    int dq;
    dq = int'(rom(map_addr(2, m_bank[2], m_a)));
    m_bank[0] = int'(d) % 8;
    m_bank[1] = int'(d) % 8;
    m_bank[2] = int'(d) & dq & 7;
    prg_a = a;
    prg_d = d;
    prg_nce = 1'b0;
    prg_rnw = 1'b0;
    tick();
    prg_nce = 1'b1;
    prg_rnw = 1'b1;
    settle("write_settle");
    m_a = a;
  endtask

  task automatic read_check(input logic [14:0] a, input string nm);
    logic [AW-1:0] e;
    set_read(a, nm);
    m_a = a;
    for (int g = 0; g < 3; g++) begin
      e = map_addr(g, m_bank[g], a);
      chk($sformatf("%s_addr%0d", nm, g), 32'(maddr[g]), 32'(e));
      chk($sformatf("%s_data%0d", nm, g), 32'(d_out[g]), 32'(rom(e)));
    end
  endtask

  typedef struct {
    logic [7:0]    d;
    logic [14:0]   a;
    logic [AW-1:0] e_def;
    logic [AW-1:0] e_m180;
  } prg_vec_t;

  typedef struct {
    logic [13:0] a;
    logic        rnw;
    logic        nce;
    logic        a10_v;
    logic        a10_h;
    logic        we;
  } chr_vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prg_vec_t    pv [7];
    chr_vec_t    cv [6];
    logic [14:0] ra;
    bit          got;
    int          base_req;
    int          base_done;

    pv[0] = '{8'h05, 15'h1234, 21'h15234, 21'h01234};
    pv[1] = '{8'h05, 15'h4010, 21'h1C010, 21'h14010};
    pv[2] = '{8'h03, 15'h0000, 21'h0C000, 21'h00000};
    pv[3] = '{8'h03, 15'h4000, 21'h1C000, 21'h0C000};
    pv[4] = '{8'hFA, 15'h7FFF, 21'h1FFFF, 21'h0BFFF};
    pv[5] = '{8'h08, 15'h3ABC, 21'h03ABC, 21'h03ABC};
    pv[6] = '{8'h01, 15'h5555, 21'h1D555, 21'h05555};

    cv[0] = '{14'h2800, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    cv[1] = '{14'h2400, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    cv[2] = '{14'h0400, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    cv[3] = '{14'h0800, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    cv[4] = '{14'h3C00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    cv[5] = '{14'h1FFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    // Power-up: held in HOLD while the preload is incomplete
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_mem_req", 32'(mreq[0]), 32'd0);
      chk("hold_rst_out", 32'(rsto[0]), 32'd1);
    end
    init_done = 1'b1;
    wait_req("first_req_seen");
    for (int g = 0; g < 3; g++)
      chk($sformatf("first_req_addr%0d", g), 32'(maddr[g]), 32'h00123);
    chk("rst_out_during_fetch", 32'(rsto[0]), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = mrdy[0];
    end
    chk("first_ready_seen", 32'(got), 32'd1);
    chk("rst_out_at_ready", 32'(rsto[0]), 32'd1);
    tick();
    chk("rst_out_after_ready", 32'(rsto[0]), 32'd0);
    settle("boot_settle");

    for (int i = 0; i < 7; i++) begin
      do_write(pv[i].d, 15'h0000);
      set_read(pv[i].a, "tbl_settle");
      m_a = pv[i].a;
      chk($sformatf("tbl%0d_addr_def", i), 32'(maddr[0]), 32'(pv[i].e_def));
      chk($sformatf("tbl%0d_addr_m180", i), 32'(maddr[1]), 32'(pv[i].e_m180));
      chk($sformatf("tbl%0d_data_def", i), 32'(d_out[0]), 32'(rom(pv[i].e_def)));
      chk($sformatf("tbl%0d_data_m180", i), 32'(d_out[1]), 32'(rom(pv[i].e_m180)));
      chk($sformatf("tbl%0d_addr_bc", i), 32'(maddr[2]),
          32'(map_addr(2, m_bank[2], pv[i].a)));
    end

    for (int i = 0; i < 6; i++) begin
      chr_a = cv[i].a;
      chr_rnw = cv[i].rnw;
      #1;
      chk($sformatf("chr%0d_nce", i), 32'(nce_o[0]), 32'(cv[i].nce));
      chk($sformatf("chr%0d_a10_v", i), 32'(a10_o[0]), 32'(cv[i].a10_v));
      chk($sformatf("chr%0d_a10_h", i), 32'(a10_o[1]), 32'(cv[i].a10_h));
      chk($sformatf("chr%0d_we", i), 32'(we_o[0]), 32'(cv[i].we));
    end

    for (int i = 0; i < 80; i++) begin
      lat = int'($urandom_range(1, 4));
      ra = 15'($urandom);
      if ($urandom_range(0, 2) == 0) do_write(8'($urandom), ra);
      read_check(15'($urandom), $sformatf("rnd%0d", i));
    end

    // Address moves mid-fetch: old fetch completes, then exactly one refetch
    lat = 1;
    read_check(15'h0100, "pre_move");
    lat = 4;
    base_req = req_cnt[0];
    base_done = done_cnt[0];
    prg_a = 15'h0000;
    wait_req("move_req_seen");
    chk("move_first_addr", 32'(maddr[0]), 32'(map_addr(0, m_bank[0], 15'h0000)));
    prg_a = 15'h0001;
    settle("move_settle");
    m_a = 15'h0001;
    chk("move_req_count", 32'(req_cnt[0] - base_req), 32'd2);
    chk("move_done_old", 32'(done_addr[0][base_done % 256]),
        32'(map_addr(0, m_bank[0], 15'h0000)));
    chk("move_done_new", 32'(done_addr[0][(base_done + 1) % 256]),
        32'(map_addr(0, m_bank[0], 15'h0001)));
    chk("move_final_data", 32'(d_out[0]), 32'(rom(map_addr(0, m_bank[0], 15'h0001))));
    prg_nce = 1'b1;
    #1;
    for (int g = 0; g < 3; g++)
      chk($sformatf("deselect_zero%0d", g), 32'(d_out[g]), 32'd0);

    // Bus conflict against a known ROM byte, with a strobe held for 5 cycles
    lat = 2;
    ovr_en[2] = 1'b1;
    ovr_val[2] = 8'h06;
    set_read(15'h0200, "bc_pre");
    chk("bc_data_q", 32'(d_out[2]), 32'h06);
    prg_d = 8'h07;
    prg_rnw = 1'b0;
    tick();
    prg_d = 8'h01;
    repeat (4) tick();
    prg_nce = 1'b1;
    prg_rnw = 1'b1;
    set_read(15'h0123, "bc_post");
    chk("held_strobe_def", 32'(maddr[0]), 32'h1C123);
    chk("bc_bank_masked", 32'(maddr[2]), 32'h18123);
    chk("bc_data_after", 32'(d_out[2]), 32'h06);
    set_read(15'h4123, "bc_post_hi");
    chk("held_strobe_m180", 32'(maddr[1]), 32'h1C123);
    ovr_en[2] = 1'b0;

    // Reset in the middle of a fetch; the late ready must be ignored
    lat = 3;
    for (int g = 0; g < 3; g++) begin
      ovr_en[g] = 1'b1;
      ovr_val[g] = 8'hA5;
    end
    prg_a = 15'h0456;
    wait_req("rst_mid_req_seen");
    tick();
    tick();
    rst = 1'b1;
    init_done = 1'b0;
    tick();
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_mid_req_drop%0d", g), 32'(mreq[g]), 32'd0);
      chk($sformatf("rst_mid_rst_out%0d", g), 32'(rsto[g]), 32'd1);
    end
    rst = 1'b0;
    repeat (4) tick();
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_mid_data%0d", g), 32'(d_out[g]), 32'd0);
      chk($sformatf("rst_mid_hold_req%0d", g), 32'(mreq[g]), 32'd0);
      chk($sformatf("rst_mid_hold_rst_out%0d", g), 32'(rsto[g]), 32'd1);
    end
    for (int g = 0; g < 3; g++) ovr_en[g] = 1'b0;
    init_done = 1'b1;
    settle("recover_settle");
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("recover_rst_out%0d", g), 32'(rsto[g]), 32'd0);
      chk($sformatf("recover_addr%0d", g), 32'(maddr[g]), 32'h00456);
      chk($sformatf("recover_data%0d", g), 32'(d_out[g]), 32'(rom(21'h00456)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
